// File: rtl/seven_segment_scan_decoder.sv
// Receive side of a multiplexed seven-segment bus: synchronizes the active-low
// digit/segment lines, decodes captured digits and publishes stable 4-digit frames.
module seven_segment_scan_decoder #(
  parameter int          STABLE_SCANS = 2,
  parameter int          SETTLE       = 4,
  parameter logic [15:0] TIMEOUT      = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  digit_in,
  input  logic [6:0]  display_in,
  output logic [15:0] values,
  output logic        updated,
  output logic        frame_valid,
  output logic        illegal_digit,
  output logic        bad_pattern,
  output logic        scan_lost
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int SW = $clog2(STABLE_SCANS + 1);
  localparam logic [CW-1:0] SETTLE_M1 = CW'(SETTLE - 1);
  localparam logic [SW-1:0] SS_MAX    = SW'(STABLE_SCANS);

  logic [10:0]   sync1_q, sync2_q, prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          armed_q, armed_d;
  logic [3:0]    seen_q, seen_d;
  logic [15:0]   frame_q, frame_d;
  logic [15:0]   cand_q, cand_d;
  logic [SW-1:0] stable_q, stable_d;
  logic [15:0]   values_q, values_d;
  logic [15:0]   wd_q, wd_d;
  logic          updated_q, frame_valid_q, illegal_q, bad_q;

  logic       same, settle_hit, legal, cap_legal, cap_illegal, seg_bad;
  logic       frame_done, publish;
  logic [1:0] pos;
  logic [3:0] code;

  // Segment patterns are active-low, bit order GFEDCBA.
  always_comb begin
    seg_bad = 1'b0;
    case (sync2_q[6:0])
      7'b1000000: code = 4'd0;
      7'b1111001: code = 4'd1;
      7'b0100100: code = 4'd2;
      7'b0110000: code = 4'd3;
      7'b0011001: code = 4'd4;
      7'b0010010: code = 4'd5;
      7'b0000010: code = 4'd6;
      7'b1111000: code = 4'd7;
      7'b0000000: code = 4'd8;
      7'b0010000: code = 4'd9;
      7'b0111111: code = 4'd10;
      7'b1111111: code = 4'd15;
      default: begin
        code    = 4'd14;
        seg_bad = 1'b1;
      end
    endcase
  end

  always_comb begin
    legal = 1'b1;
    pos   = 2'd0;
    case (sync2_q[10:7])
      4'b1110: pos = 2'd0;
      4'b1101: pos = 2'd1;
      4'b1011: pos = 2'd2;
      4'b0111: pos = 2'd3;
      default: legal = 1'b0;
    endcase
  end

  // One capture per dwell: armed by any change, disarmed by the capture itself.
  always_comb begin
    same        = (sync2_q == prev_q);
    settle_hit  = armed_q && same && (cnt_q == SETTLE_M1);
    cap_legal   = settle_hit && legal;
    cap_illegal = settle_hit && !legal;
    if (!same)                    cnt_d = '0;
    else if (cnt_q == SETTLE_M1)  cnt_d = cnt_q;
    else                          cnt_d = cnt_q + 1'b1;
    if (!same)           armed_d = 1'b1;
    else if (settle_hit) armed_d = 1'b0;
    else                 armed_d = armed_q;
  end

  always_comb begin
    frame_done = (seen_q == 4'b1111);
    seen_d     = frame_done ? 4'b0000 : seen_q;
    frame_d    = frame_q;
    if (cap_legal) begin
      seen_d[pos]              = 1'b1;
      frame_d[{pos, 2'b00} +: 4] = code;
    end
  end

  // Publish only on the scan where the count first reaches the threshold.
  always_comb begin
    cand_d   = cand_q;
    stable_d = stable_q;
    publish  = 1'b0;
    if (frame_done) begin
      if (frame_q == cand_q) begin
        stable_d = (stable_q == SS_MAX) ? SS_MAX : stable_q + 1'b1;
      end else begin
        cand_d   = frame_q;
        stable_d = SW'(1);
      end
      publish = (stable_d == SS_MAX) &&
                ((stable_q != SS_MAX) || (frame_q != cand_q)) &&
                (cand_d != values_q);
    end
    values_d = publish ? cand_d : values_q;
  end

  always_comb begin
    if (cap_legal)         wd_d = TIMEOUT;
    else if (wd_q != 16'd0) wd_d = wd_q - 16'd1;
    else                   wd_d = wd_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q       <= 11'h7FF;
      sync2_q       <= 11'h7FF;
      prev_q        <= 11'h7FF;
      cnt_q         <= '0;
      armed_q       <= 1'b0;
      seen_q        <= 4'b0000;
      frame_q       <= 16'hFFFF;
      cand_q        <= 16'hFFFF;
      stable_q      <= '0;
      values_q      <= 16'hFFFF;
      wd_q          <= TIMEOUT;
      updated_q     <= 1'b0;
      frame_valid_q <= 1'b0;
      illegal_q     <= 1'b0;
      bad_q         <= 1'b0;
    end else begin
      sync1_q       <= {digit_in, display_in};
      sync2_q       <= sync1_q;
      prev_q        <= sync2_q;
      cnt_q         <= cnt_d;
      armed_q       <= armed_d;
      seen_q        <= seen_d;
      frame_q       <= frame_d;
      cand_q        <= cand_d;
      stable_q      <= stable_d;
      values_q      <= values_d;
      wd_q          <= wd_d;
      updated_q     <= publish;
      frame_valid_q <= frame_done;
      illegal_q     <= cap_illegal;
      bad_q         <= cap_legal && seg_bad;
    end
  end

  assign values        = values_q;
  assign updated       = updated_q;
  assign frame_valid   = frame_valid_q;
  assign illegal_digit = illegal_q;
  assign bad_pattern   = bad_q;
  assign scan_lost     = (wd_q == 16'd0);

endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
// Directed bench for seven_segment_scan_decoder: scans, stability, glitches,
// illegal digits, bad patterns, watchdog and mid-frame reset.
module tb_seven_segment_scan_decoder;

  localparam logic [6:0] S0   = 7'b1000000;
  localparam logic [6:0] S1   = 7'b1111001;
  localparam logic [6:0] S2   = 7'b0100100;
  localparam logic [6:0] S4   = 7'b0011001;
  localparam logic [6:0] DASH = 7'b0111111;
  localparam logic [6:0] BADP = 7'b0101010;
  localparam logic [6:0] BLNK = 7'b1111111;

  logic        clk, rst;
  logic [3:0]  digit_in;
  logic [6:0]  display_in;
  logic [15:0] values;
  logic        updated, frame_valid, illegal_digit, bad_pattern, scan_lost;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int fv_cnt = 0, upd_cnt = 0, ill_cnt = 0, bad_cnt = 0;
  int last_fv_cyc = 0, last_bad_cyc = 0, lost_rise_cyc = 0, lost_fall_cyc = 0;
  logic lost_prev = 1'b0;
  logic [15:0] exp_q[$];

  seven_segment_scan_decoder #(
    .STABLE_SCANS(2),
    .SETTLE(4),
    .TIMEOUT(16'd20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .digit_in(digit_in),
    .display_in(display_in),
    .values(values),
    .updated(updated),
    .frame_valid(frame_valid),
    .illegal_digit(illegal_digit),
    .bad_pattern(bad_pattern),
    .scan_lost(scan_lost)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // monitor and scoreboard, sampled on the falling edge
  always @(negedge clk) begin
    if (frame_valid === 1'b1) begin
      fv_cnt++;
      last_fv_cyc = cyc;
    end
    if (illegal_digit === 1'b1) ill_cnt++;
    if (bad_pattern === 1'b1) begin
      bad_cnt++;
      last_bad_cyc = cyc;
    end
    if (scan_lost === 1'b1 && lost_prev === 1'b0) lost_rise_cyc = cyc;
    if (scan_lost === 1'b0 && lost_prev === 1'b1) lost_fall_cyc = cyc;
    lost_prev = scan_lost;
    if (updated === 1'b1) begin
      upd_cnt++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL upd_unexpected: observed values %0h expected no update", values);
      end else begin
        chk("upd_values", {16'h0, values}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  // driver tasks
  task automatic hold(input logic [3:0] d, input logic [6:0] s, input int n);
    digit_in   = d;
    display_in = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scan(input logic [6:0] s0, input logic [6:0] s1,
                      input logic [6:0] s2, input logic [6:0] s3);
    hold(4'b1110, s0, 8);
    hold(4'b1101, s1, 8);
    hold(4'b1011, s2, 8);
    hold(4'b0111, s3, 10);
  endtask

  initial begin
    rst = 1'b1;
    digit_in = 4'b1111;
    display_in = BLNK;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_values", {16'h0, values}, 32'hFFFF);
    chk("rst_updated", {31'h0, updated}, 32'h0);
    chk("rst_frame_valid", {31'h0, frame_valid}, 32'h0);
    chk("rst_illegal", {31'h0, illegal_digit}, 32'h0);
    chk("rst_bad", {31'h0, bad_pattern}, 32'h0);
    chk("rst_scan_lost", {31'h0, scan_lost}, 32'h0);
    rst = 1'b0;

    // first scan starts a candidate, second publishes 0412
    scan(S2, S1, S4, S0);
    chk("scan1_fv", fv_cnt, 1);
    chk("scan1_upd", upd_cnt, 0);
    exp_q.push_back(16'h0412);
    scan(S2, S1, S4, S0);
    chk("scan2_fv", fv_cnt, 2);
    chk("scan2_upd", upd_cnt, 1);
    chk("scan2_values", {16'h0, values}, 32'h0412);

    // five identical scans: frames but no new update
    for (int i = 0; i < 5; i++) scan(S2, S1, S4, S0);
    chk("same5_fv", fv_cnt, 7);
    chk("same5_upd", upd_cnt, 1);

    // pos2 becomes dash
    exp_q.push_back(16'h0A12);
    scan(S2, S1, DASH, S0);
    chk("dash1_upd", upd_cnt, 1);
    scan(S2, S1, DASH, S0);
    chk("dash2_fv", fv_cnt, 9);
    chk("dash2_upd", upd_cnt, 2);
    chk("dash2_values", {16'h0, values}, 32'h0A12);

    // illegal digit select, then undecodable pattern on pos0
    hold(4'b1100, S1, 8);
    exp_q.push_back(16'h0A1E);
    scan(BADP, S1, DASH, S0);
    chk("illegal_cnt", ill_cnt, 1);
    chk("illegal_fv", fv_cnt, 10);
    scan(BADP, S1, DASH, S0);
    chk("bad_cnt", bad_cnt, 2);
    chk("bad_fv", fv_cnt, 11);
    chk("bad_upd", upd_cnt, 3);
    chk("bad_values", {16'h0, values}, 32'h0A1E);

    // 2-cycle glitch on pos1 is not captured, frame stays incomplete
    hold(4'b1110, S0, 8);
    hold(4'b1101, S0, 2);
    hold(4'b1110, S0, 8);
    hold(4'b1011, DASH, 8);
    hold(4'b0111, S0, 10);
    chk("glitch_fv", fv_cnt, 11);
    chk("glitch_ill", ill_cnt, 1);

    // pos1 completes the frame, then the bus stops
    hold(4'b1101, S1, 40);
    chk("wd_fv", fv_cnt, 12);
    chk("wd_upd", upd_cnt, 3);
    chk("wd_lost", {31'h0, scan_lost}, 32'h1);
    chk("wd_delay", lost_rise_cyc - last_fv_cyc, 19);

    // a legal capture clears scan_lost on its own edge
    hold(4'b1110, BADP, 10);
    chk("wd_clear_lost", {31'h0, scan_lost}, 32'h0);
    chk("wd_clear_bad", bad_cnt, 3);
    chk("wd_clear_edge", lost_fall_cyc, last_bad_cyc);

    // reset after three digits discards the partial frame
    hold(4'b1110, S2, 8);
    hold(4'b1101, S1, 8);
    hold(4'b1011, S4, 8);
    chk("partial_fv", fv_cnt, 12);
    rst = 1'b1;
    hold(4'b1111, BLNK, 3);
    chk("mid_rst_values", {16'h0, values}, 32'hFFFF);
    rst = 1'b0;
    scan(S2, S1, S4, S0);
    chk("post_rst_fv", fv_cnt, 13);
    chk("post_rst_upd", upd_cnt, 3);
    chk("post_rst_values", {16'h0, values}, 32'hFFFF);
    chk("exp_q_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
